// File: rtl/pipelined_cla.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead block per stage.
// Latency: NSTAGE = WIDTH/GROUP cycles from accept edge to OUT_VALID; one result per cycle.
// Backpressure: whole pipe shifts only when !OUT_VALID | OUT_READY; IN_READY mirrors that.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   IN_VALID/IN_READY   operand handshake; A, B, CIN, SUB sampled on transfer
//   OUT_VALID/OUT_READY result handshake; SUM, COUT, OVF held while stalled or idle
//
// Each stage k resolves bits [k*GROUP +: GROUP] from the carry registered by
// stage k-1, then forwards only the operand bits that later stages still need.
module pipelined_cla #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);
    localparam int NSTAGE = WIDTH / GROUP;

    if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
        $error("pipelined_cla: WIDTH must be a non-zero multiple of GROUP");
    end

    // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci,
    // so no carry ripples through a chain of per-bit cells inside the group.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             ci
    );
        logic [GROUP:0] c;
        logic           run;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i];
            run    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run & g[j]);
                run    = run & p[j];
            end
            c[i+1] = c[i+1] | (run & ci);
        end
        return c;
    endfunction

    logic advance;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int LO = k * GROUP;
        localparam int HI = LO + GROUP;

        // Stage inputs: bits [WIDTH-1:LO] of the operands, incoming carry,
        // and the finished low sum bits (if any) from the previous stage.
        logic                vld_in;
        logic                c_in;
        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic [HI-1:0]       sum_new;

        logic [GROUP-1:0]    grp_g;
        logic [GROUP-1:0]    grp_p;
        logic [GROUP:0]      grp_c;

        logic                vld_q, vld_d;
        logic                cout_q, cout_d;
        logic [HI-1:0]       sum_q, sum_d;

        if (k == 0) begin : g_src
            assign vld_in  = IN_VALID;
            assign c_in    = CIN;
            assign a_in    = A;
            // Subtraction folds into the add as A + ~B + CIN.
            assign b_in    = SUB ? ~B : B;
            assign sum_new = grp_p ^ grp_c[GROUP-1:0];
        end else begin : g_src
            assign vld_in  = g_stg[k-1].vld_q;
            assign c_in    = g_stg[k-1].cout_q;
            assign a_in    = g_stg[k-1].g_fwd.opa_q;
            assign b_in    = g_stg[k-1].g_fwd.opb_q;
            assign sum_new = {grp_p ^ grp_c[GROUP-1:0], g_stg[k-1].sum_q};
        end

        always_comb begin
            grp_g = a_in[GROUP-1:0] & b_in[GROUP-1:0];
            grp_p = a_in[GROUP-1:0] ^ b_in[GROUP-1:0];
            grp_c = lookahead(grp_g, grp_p, c_in);
        end

        // Data registers load only on a valid transfer so that bubbles leave
        // the last result visible on SUM/COUT/OVF.
        always_comb begin
            vld_d  = vld_q;
            cout_d = cout_q;
            sum_d  = sum_q;
            if (advance) begin
                vld_d = vld_in;
                if (vld_in) begin
                    cout_d = grp_c[GROUP];
                    sum_d  = sum_new;
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                vld_q  <= 1'b0;
                cout_q <= 1'b0;
                sum_q  <= '0;
            end else begin
                vld_q  <= vld_d;
                cout_q <= cout_d;
                sum_q  <= sum_d;
            end
        end

        // Unconsumed operand bits travel on to later stages only.
        if (k < NSTAGE - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] opa_q, opa_d;
            logic [WIDTH-HI-1:0] opb_q, opb_d;

            always_comb begin
                opa_d = opa_q;
                opb_d = opb_q;
                if (advance && vld_in) begin
                    opa_d = a_in[WIDTH-LO-1:GROUP];
                    opb_d = b_in[WIDTH-LO-1:GROUP];
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        // The carry into the MSB only exists in the final group; keep it for OVF.
        if (k == NSTAGE - 1) begin : g_last
            logic msb_c_q, msb_c_d;

            always_comb begin
                msb_c_d = msb_c_q;
                if (advance && vld_in) begin
                    msb_c_d = grp_c[GROUP-1];
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    msb_c_q <= 1'b0;
                end else begin
                    msb_c_q <= msb_c_d;
                end
            end
        end
    end

    assign OUT_VALID = g_stg[NSTAGE-1].vld_q;
    assign SUM       = g_stg[NSTAGE-1].sum_q;
    assign COUT      = g_stg[NSTAGE-1].cout_q;
    assign OVF       = g_stg[NSTAGE-1].cout_q ^ g_stg[NSTAGE-1].g_last.msb_c_q;

endmodule

// File: tb/tb_pipelined_cla.sv
// Testbench for pipelined_cla: 16/4 instance with scoreboard plus exhaustive 4/4 instance.
// Latency checked at 4 cycles (16-bit) and 1 cycle (4-bit).
// Backpressure exercised with a 1,0,0 OUT_READY pattern and a mid-flight reset.
module tb_pipelined_cla;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [15:0] sum;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        cin4 = 1'b0;
    logic        sub4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    int   nvec = 0;
    int   nerr = 0;
    res_t sb[$];
    res_t sb4[$];
    res_t last_out = '0;

    always #5 clk = ~clk;

    pipelined_cla #(.WIDTH(16), .GROUP(4)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CIN(cin), .SUB(sub),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .COUT(cout), .OVF(ovf)
    );

    pipelined_cla #(.WIDTH(4), .GROUP(4)) dut4 (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid4), .IN_READY(in_ready4),
        .A(a4), .B(b4), .CIN(cin4), .SUB(sub4),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready4),
        .SUM(sum4), .COUT(cout4), .OVF(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                   input logic ci, input logic si);
        logic [31:0] mask, x, y, t;
        res_t        r;
        mask   = (32'd1 << w) - 32'd1;
        x      = {16'd0, ai} & mask;
        y      = (si ? ~{16'd0, bi} : {16'd0, bi}) & mask;
        t      = x + y + {31'd0, ci};
        r.sum  = t[15:0] & mask[15:0];
        r.cout = t[w];
        r.ovf  = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
        return r;
    endfunction

    // Presents one operand set and returns just after the edge that accepts it.
    task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic si);
        bit done;
        done     = 1'b0;
        a        = ai;
        b        = bi;
        cin      = ci;
        sub      = si;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(16, ai, bi, ci, si));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 32'(done), 1);
    endtask

    // Called right after an accept edge with nothing else in flight.
    task automatic lat_check(input string tag);
        in_valid = 1'b0;
        chk(tag, 32'(out_valid), 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk(tag, 32'(out_valid), 32'(i == 3));
        end
    endtask

    // Scoreboard monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 0);
                end else begin
                    chk("sum", 32'(sum), 32'(sb[0].sum));
                    chk("cout", 32'(cout), 32'(sb[0].cout));
                    chk("ovf", 32'(ovf), 32'(sb[0].ovf));
                    if (out_ready) last_out = sb.pop_front();
                end
            end else begin
                chk("idle_hold", 32'({ovf, cout, sum}), 32'(last_out));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", nvec, nerr);
        $fatal(1);
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_outputs", 32'({ovf, cout, sum}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // First accept on the first edge after reset release, then latency
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        lat_check("lat_basic");
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        lat_check("lat_ripple");
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back stream with OUT_READY pattern 1,0,0,...
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (i % 3 == 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(sb.size()), 0);

        // Reset mid-flight: two accepted, reset for half a cycle, then a fresh one
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        sb.delete();
        last_out = '0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        lat_check("lat_after_rst");
        repeat (2) @(posedge clk);
        #1;

        // Exhaustive 4-bit sweep, 1-cycle latency, result compared the cycle after drive
        for (int n = 0; n <= 1024; n++) begin
            @(negedge clk);
            if (out_valid4) begin
                chk("lat4", 32'(sb4.size()), 1);
                if (sb4.size() != 0) begin
                    chk("sum4", 32'({ovf4, cout4, sum4}),
                        32'({sb4[0].ovf, sb4[0].cout, sb4[0].sum[3:0]}));
                    void'(sb4.pop_front());
                end
            end else if (n > 0) begin
                chk("vld4", 32'(out_valid4), 1);
            end
            if (n < 1024) begin
                a4        = n[3:0];
                b4        = n[7:4];
                cin4      = n[8];
                sub4      = n[9];
                in_valid4 = 1'b1;
                sb4.push_back(model(4, {12'd0, n[3:0]}, {12'd0, n[7:4]}, n[8], n[9]));
            end else begin
                in_valid4 = 1'b0;
            end
        end
        @(negedge clk);
        chk("drain4", 32'(sb4.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipelined_cla.md
PIPELINED_CLA -- requirements
Module: pipelined_cla

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of GROUP, minimum GROUP.
REQ-002 Parameter GROUP, default 4, bits per carry-lookahead group (one pipeline stage per group).
REQ-003 Derived NSTAGE = WIDTH/GROUP SHALL be the pipeline depth; an illegal WIDTH/GROUP combination SHALL stop elaboration.
REQ-004 Ports SHALL be:
CLK        in   1      single clock, all state on rising edge.
RST        in   1      reset, asynchronous, active-high.
IN_VALID   in   1      operand set presented.
IN_READY   out  1      block can accept operands this cycle.
A          in   WIDTH  operand A, unsigned or two's complement.
B          in   WIDTH  operand B.
CIN        in   1      carry in to bit 0.
SUB        in   1      1 = subtract mode (B inverted).
OUT_VALID  out  1      result presented.
OUT_READY  in   1      downstream accepts result.
SUM        out  WIDTH  result.
COUT       out  1      carry out of bit WIDTH-1.
OVF        out  1      signed overflow.

Function
REQ-005 Arithmetic SHALL be {COUT,SUM} = A + (SUB ? ~B : B) + CIN, in WIDTH+1 bits; subtraction A-B uses SUB=1, CIN=1.
REQ-006 OVF SHALL equal carry into bit WIDTH-1 XOR COUT.
REQ-007 Stage k (0..NSTAGE-1) SHALL compute bits [k*GROUP +: GROUP] with group generate/propagate lookahead from the carry registered by stage k-1 (stage 0 uses CIN).
REQ-008 Each stage SHALL register: valid bit, finished low sum bits, group carry out, unconsumed upper operand bits, and the carry into the MSB once computed.
REQ-009 Advance = !OUT_VALID | OUT_READY; all stages SHALL shift together only when Advance=1, and hold all contents otherwise.
REQ-010 IN_READY SHALL equal Advance (combinational); a transfer occurs when IN_VALID & IN_READY at a rising edge.
REQ-011 A cycle with Advance=1 and no transfer SHALL insert a bubble (valid=0) into stage 0; bubbles are not squeezed out.
REQ-012 Latency SHALL be exactly NSTAGE cycles from accept edge to OUT_VALID=1 with no stall; throughput one result per cycle with OUT_READY held 1.
REQ-013 Results SHALL emerge in acceptance order; none dropped or duplicated under any OUT_READY pattern.
REQ-014 While OUT_VALID=1 and OUT_READY=0, SUM/COUT/OVF SHALL remain stable.
REQ-015 SUM/COUT/OVF SHALL be don't-care-free: when OUT_VALID=0 they SHALL hold their last registered value.
REQ-016 Simultaneous output consume and input accept in one cycle SHALL both take effect.
REQ-017 NSTAGE=1 (WIDTH=GROUP) SHALL give 1-cycle latency with identical handshake rules.

Reset
REQ-018 RST=1 SHALL asynchronously clear all stage valid bits, SUM, COUT, OVF and all internal data registers to 0.
REQ-019 During and after reset IN_READY SHALL be 1 (OUT_VALID=0).
REQ-020 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear after it.
REQ-021 First accept SHALL be possible on the first rising edge after RST deasserts.

Verification (WIDTH=16, GROUP=4, latency 4)
REQ-022 A=0x1234, B=0x1111, CIN=0, SUB=0, OUT_READY=1 -> 4 cycles later OUT_VALID=1, SUM=0x2345, COUT=0, OVF=0.
REQ-023 A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1, OVF=0 (full ripple through all groups); A=0x7FFF, B=0x0001 -> SUM=0x8000, COUT=0, OVF=1.
REQ-024 A=0x0005, B=0x0007, SUB=1, CIN=1 -> SUM=0xFFFE, COUT=0, OVF=0; A=0x8000, B=0x0001, SUB=1, CIN=1 -> SUM=0x7FFF, COUT=1, OVF=1.
REQ-025 Back-to-back stream of 8 operand pairs with OUT_READY toggling 1,0,0,1,... -> 8 results in order, each matching REQ-005, stable while stalled, IN_READY=0 exactly when OUT_VALID=1 & OUT_READY=0.
REQ-026 Accept 3 operations, assert RST for one half-cycle after second accept -> OUT_VALID=0 immediately, no results emitted, IN_READY=1; next accepted operation returns after 4 cycles.
REQ-027 Exhaustive 4-bit sweep at WIDTH=4, GROUP=4, all A, B, CIN, SUB -> every result matches reference model with 1-cycle latency.
